// File: rtl/ahb_ram_secded_pkg.sv
// Shared states, bus encodings and the 32-bit SEC-DED check-bit function
// for the AHB-Lite SRAM slave with SEC-DED read checksums.
package ahb_ram_secded_pkg;

   typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} ahb_ram_st_t;

   typedef enum logic [1:0] {ERR_NONE, ERR_RANGE, ERR_SIZE, ERR_ALIGN} ahb_err_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   // Data bits fill the non-power-of-two positions 3..38 of a Hamming codeword;
   // chk[5:0] is the XOR of those positions, chk[6] is overall parity.
   function automatic logic [6:0] secded_enc32(input logic [31:0] data);
      logic [6:0] chk;
      int         di;
      chk = '0;
      di  = 0;
      for (int pos = 1; pos < 39; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            if (data[di[4:0]]) chk[5:0] = chk[5:0] ^ pos[5:0];
            di++;
         end
      end
      chk[6] = (^data) ^ (^chk[5:0]);
      return chk;
   endfunction

endpackage

// File: rtl/ahb_ram_secded_encoder.sv
// Thin combinational wrapper around the shared SEC-DED check-bit function.
module secded_encoder_32
   import ahb_ram_secded_pkg::*;
(
   input  logic [31:0] data_i,
   output logic [6:0]  check_o
);

   assign check_o = secded_enc32(data_i);

endmodule

// File: rtl/ahb_ram_secded.sv
// AHB-Lite zero-wait SRAM slave returning SEC-DED checksums with read data.
// Optional write-checksum verification is enabled by defining AHB_WCHECK_EN.
module ahb_ram_secded
   import ahb_ram_secded_pkg::*;
#(
   parameter int unsigned MEM_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
)(
   input  logic        s_clk_i,
   input  logic        s_resetn_i,
   input  logic        s_hsel_i,
   input  logic [31:0] s_haddr_i,
   input  logic [1:0]  s_htrans_i,
   input  logic        s_hwrite_i,
   input  logic [2:0]  s_hsize_i,
   input  logic        s_hready_i,
   input  logic [31:0] s_hwdata_i,
   input  logic [6:0]  s_hwchecksum_i,
   output logic [31:0] s_hrdata_o,
   output logic [6:0]  s_hrchecksum_o,
   output logic        s_hreadyout_o,
   output logic        s_hresp_o
);

   localparam int unsigned AW = $clog2(MEM_WORDS);

   logic [31:0]  mem [MEM_WORDS];

   ahb_ram_st_t  state_q;
   logic         isWrite_q;
   logic [AW-1:0] wordIdx_q;
   logic [1:0]   byteOff_q;
   logic [2:0]   size_q;

   logic         acceptAddr;
   ahb_err_t     errClass;
   logic         readPhase;
   logic         writePhase;
   logic         wchkErr;
   logic         doWrite;
   logic [3:0]   laneEn;
   logic         unusedBits;

   assign unusedBits = s_htrans_i[0];
   assign acceptAddr = s_hsel_i & s_hready_i & s_htrans_i[1];
   assign readPhase  = (state_q == DATA) & ~isWrite_q;
   assign writePhase = (state_q == DATA) & isWrite_q;

   always_comb begin
      errClass = ERR_NONE;
      if (s_haddr_i[31:AW+2] != BASE_ADDR[31:AW+2])
         errClass = ERR_RANGE;
      else if (s_hsize_i > HSIZE_WORD)
         errClass = ERR_SIZE;
      else if ((s_hsize_i == HSIZE_HALF && s_haddr_i[0]) ||
               (s_hsize_i == HSIZE_WORD && s_haddr_i[1:0] != 2'b00))
         errClass = ERR_ALIGN;
   end

`ifdef AHB_WCHECK_EN
   logic [6:0] wdataChk;

   secded_encoder_32 u_wenc (
      .data_i  (s_hwdata_i),
      .check_o (wdataChk)
   );

   assign wchkErr = writePhase & (wdataChk != s_hwchecksum_i);
`else
   logic unusedWchk;
   assign unusedWchk = ^s_hwchecksum_i;
   assign wchkErr    = 1'b0;
`endif

   assign doWrite = writePhase & ~wchkErr;

   always_comb begin
      laneEn = 4'b0000;
      case (size_q)
         HSIZE_BYTE: laneEn[byteOff_q] = 1'b1;
         HSIZE_HALF: laneEn = byteOff_q[1] ? 4'b1100 : 4'b0011;
         default:    laneEn = 4'b1111;
      endcase
   end

   // The array has no reset; writes are gated by the async-reset FSM state.
   always_ff @(posedge s_clk_i) begin
      if (doWrite) begin
         for (int b = 0; b < 4; b++) begin
            if (laneEn[b]) mem[wordIdx_q][8*b +: 8] <= s_hwdata_i[8*b +: 8];
         end
      end
   end

   always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
      if (!s_resetn_i) begin
         state_q   <= IDLE;
         isWrite_q <= 1'b0;
         wordIdx_q <= '0;
         byteOff_q <= '0;
         size_q    <= '0;
      end else begin
         if (state_q == ERR1 || wchkErr) begin
            state_q <= ERR2;
         end else if (acceptAddr) begin
            state_q   <= (errClass == ERR_NONE) ? DATA : ERR1;
            isWrite_q <= s_hwrite_i;
            wordIdx_q <= s_haddr_i[AW+1:2];
            byteOff_q <= s_haddr_i[1:0];
            size_q    <= s_hsize_i;
         end else begin
            state_q <= IDLE;
         end
      end
   end

   // Read data is the live array word so a write completing on the previous edge is visible.
   assign s_hrdata_o    = readPhase ? mem[wordIdx_q] : 32'h0;
   assign s_hreadyout_o = ~((state_q == ERR1) | wchkErr);
   assign s_hresp_o     = (state_q == ERR1) | (state_q == ERR2) | wchkErr;

   secded_encoder_32 u_renc (
      .data_i  (s_hrdata_o),
      .check_o (s_hrchecksum_o)
   );

endmodule

// File: tb/tb_ahb_ram_secded.sv
// Self-checking bench for ahb_ram_secded: directed cases plus randomized traffic
// compared every cycle against a transaction-level memory model.
`timescale 1ns/1ps
module tb_ahb_ram_secded;

   localparam int          MEM_WORDS = 1024;
   localparam logic [31:0] BASE_ADDR = 32'h0000_0000;
   localparam logic [31:0] REGION    = 32'(MEM_WORDS * 4);

   logic        clk = 1'b0;
   logic        resetn;
   logic        hsel;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic        hready;
   logic [31:0] hwdata;
   logic [6:0]  hwchk;
   logic [31:0] hrdata;
   logic [6:0]  hrchk;
   logic        hreadyout;
   logic        hresp;

   always #5 clk = ~clk;

   ahb_ram_secded #(.MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE_ADDR)) dut (
      .s_clk_i        (clk),
      .s_resetn_i     (resetn),
      .s_hsel_i       (hsel),
      .s_haddr_i      (haddr),
      .s_htrans_i     (htrans),
      .s_hwrite_i     (hwrite),
      .s_hsize_i      (hsize),
      .s_hready_i     (hready),
      .s_hwdata_i     (hwdata),
      .s_hwchecksum_i (hwchk),
      .s_hrdata_o     (hrdata),
      .s_hrchecksum_o (hrchk),
      .s_hreadyout_o  (hreadyout),
      .s_hresp_o      (hresp)
   );

   int checks = 0;
   int errors = 0;

   logic [31:0] model [MEM_WORDS];
   bit          known [MEM_WORDS];

   // Pending response: 0 none, 1 legal data phase, 2 first error cycle, 3 second error cycle
   int          phase = 0;
   bit          pWrite;
   int          pIdx;
   int          pOff;
   int          pSize;
   logic [31:0] pData;
   bit          pCorrupt;

   logic [31:0] lastRdata;
   logic [6:0]  lastChk;
   logic        lastReady;
   logic        lastResp;

   // Reference checksum: build the 38-bit Hamming codeword, then each check bit
   // is the parity of every codeword position whose index has that bit set.
   function automatic logic [6:0] refEnc(input logic [31:0] d);
      logic [38:0] cw;
      logic [6:0]  c;
      int          j;
      cw = '0;
      j  = 0;
      for (int p = 1; p <= 38; p++) begin
         if (p != 1 && p != 2 && p != 4 && p != 8 && p != 16 && p != 32) begin
            cw[p] = d[j];
            j++;
         end
      end
      c = '0;
      for (int k = 0; k < 6; k++)
         for (int p = 1; p <= 38; p++)
            if (((p >> k) & 1) == 1) c[k] = c[k] ^ cw[p];
      c[6] = (^d) ^ (^c[5:0]);
      return c;
   endfunction

   function automatic bit isLegal(input logic [31:0] a, input logic [2:0] s);
      if (a < BASE_ADDR || a >= BASE_ADDR + REGION) return 1'b0;
      if (s > 3'd2) return 1'b0;
      return (a % (32'd1 << s)) == 32'd0;
   endfunction

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkOutput(input logic expReady, input logic expResp,
                              input logic [31:0] expData, input bit skipData);
      lastRdata = hrdata;
      lastChk   = hrchk;
      lastReady = hreadyout;
      lastResp  = hresp;
      checkVal("hreadyout", {31'b0, hreadyout}, {31'b0, expReady});
      checkVal("hresp", {31'b0, hresp}, {31'b0, expResp});
      if (!skipData) begin
         checkVal("hrdata", hrdata, expData);
         checkVal("hrchecksum", {25'b0, hrchk}, {25'b0, refEnc(expData)});
      end
   endtask

   // One bus cycle: present an address phase (plus data for the pending write),
   // compare outputs with the model, then advance the model past the clock edge.
   task automatic applyStimulus(input bit sel, input logic [1:0] trans, input bit wr,
                                input logic [2:0] size, input logic [31:0] addr,
                                input logic [31:0] wdata, input bit corrupt);
      bit          wFail;
      bit          accept;
      logic        expReady;
      logic        expResp;
      logic [31:0] expData;
      logic [31:0] mask;
      @(negedge clk);
      wFail = 1'b0;
`ifdef AHB_WCHECK_EN
      wFail = (phase == 1) && pWrite && pCorrupt;
`endif
      expReady = !(phase == 2 || wFail);
      expResp  = (phase >= 2) || wFail;
      expData  = (phase == 1 && !pWrite && known[pIdx]) ? model[pIdx] : 32'h0;
      hready = expReady;
      hsel   = sel;
      htrans = trans;
      hwrite = wr;
      hsize  = size;
      haddr  = addr;
      if (phase == 1 && pWrite) begin
         hwdata = pData;
         hwchk  = refEnc(pData) ^ {6'b0, pCorrupt};
      end else begin
         hwdata = $urandom;
         hwchk  = 7'($urandom);
      end
      #1;
      checkOutput(expReady, expResp, expData, phase == 1 && !pWrite && !known[pIdx]);
      if (phase == 1 && pWrite && !wFail) begin
         mask = (pSize == 0) ? 32'hFF : (pSize == 1) ? 32'hFFFF : 32'hFFFF_FFFF;
         mask = mask << (8 * pOff);
         model[pIdx] = (model[pIdx] & ~mask) | (pData & mask);
         if (pSize == 2) known[pIdx] = 1'b1;
      end
      accept = sel && expReady && trans[1];
      if (phase == 2 || wFail) begin
         phase = 3;
      end else if (accept) begin
         phase    = isLegal(addr, size) ? 1 : 2;
         pWrite   = wr;
         pIdx     = int'((addr - BASE_ADDR) >> 2) % MEM_WORDS;
         pOff     = int'(addr % 4);
         pSize    = int'(size);
         pData    = wdata;
         pCorrupt = corrupt;
      end else begin
         phase = 0;
      end
   endtask

   task automatic busIdle();
      applyStimulus(1'b0, 2'b00, 1'b0, 3'd2, 32'h0, 32'h0, 1'b0);
   endtask

   task automatic busWrite(input logic [31:0] a, input logic [31:0] d, input logic [2:0] s);
      applyStimulus(1'b1, 2'b10, 1'b1, s, a, d, 1'b0);
   endtask

   task automatic busRead(input logic [31:0] a);
      applyStimulus(1'b1, 2'b10, 1'b0, 3'd2, a, 32'h0, 1'b0);
   endtask

   // Assert reset in the middle of whatever data phase is pending.
   task automatic resetDuring();
      @(negedge clk);
      if (phase == 1 && pWrite) begin
         hwdata = pData;
         hwchk  = refEnc(pData);
      end
      hsel   = 1'b0;
      htrans = 2'b00;
      hready = 1'b1;
      resetn = 1'b0;
      #1;
      checkOutput(1'b1, 1'b0, 32'h0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      phase  = 0;
   endtask

   initial begin
      logic [31:0] a;
      logic [2:0]  s;
      for (int i = 0; i < MEM_WORDS; i++) begin
         known[i] = 1'b0;
         model[i] = 32'h0;
      end
      resetn = 1'b0;
      hsel   = 1'b0;
      haddr  = 32'h0;
      htrans = 2'b00;
      hwrite = 1'b0;
      hsize  = 3'd2;
      hready = 1'b1;
      hwdata = 32'h0;
      hwchk  = 7'h0;
      #2;
      checkOutput(1'b1, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      resetn = 1'b1;

      // Word write then read
      busWrite(32'h10, 32'hDEAD_BEEF, 3'd2);
      busRead(32'h10);
      busIdle();
      checkVal("rd10_data", lastRdata, 32'hDEAD_BEEF);
      checkVal("rd10_ready", {31'b0, lastReady}, 32'd1);
      checkVal("rd10_resp", {31'b0, lastResp}, 32'd0);

      // Checksum of data value 1 pinned by hand
      busWrite(32'h0, 32'h1, 3'd2);
      busRead(32'h0);
      busIdle();
      checkVal("chk_of_1", {25'b0, lastChk}, 32'h43);

      // Byte and halfword lane writes
      busWrite(32'h10, 32'h1122_3344, 3'd2);
      busWrite(32'h13, 32'h5A00_0000, 3'd0);
      busRead(32'h10);
      busIdle();
      checkVal("byte_wr", lastRdata, 32'h5A22_3344);
      busWrite(32'h12, 32'hBEEF_0000, 3'd1);
      busRead(32'h10);
      busIdle();
      checkVal("half_wr", lastRdata, 32'hBEEF_3344);

      // Misaligned read and out-of-range write give a two-cycle error
      busRead(32'h2);
      busIdle();
      checkVal("mis_c1", {30'b0, lastReady, lastResp}, 32'b01);
      busIdle();
      checkVal("mis_c2", {30'b0, lastReady, lastResp}, 32'b11);
      busWrite(BASE_ADDR + REGION, 32'hFFFF_FFFF, 3'd2);
      busIdle();
      checkVal("oor_c1", {30'b0, lastReady, lastResp}, 32'b01);
      busIdle();
      checkVal("oor_c2", {30'b0, lastReady, lastResp}, 32'b11);
      busRead(32'h0);
      busIdle();
      checkVal("oor_nowrite", lastRdata, 32'h1);

      // Pipelined write/read/read
      busWrite(32'h24, 32'h0BAD_CAFE, 3'd2);
      busWrite(32'h20, 32'hCAFE_F00D, 3'd2);
      busRead(32'h20);
      busRead(32'h24);
      checkVal("pipe_rd20", lastRdata, 32'hCAFE_F00D);
      busIdle();
      checkVal("pipe_rd24", lastRdata, 32'h0BAD_CAFE);

      // Corrupted write checksum
      busWrite(32'h40, 32'hAAAA_5555, 3'd2);
      applyStimulus(1'b1, 2'b10, 1'b1, 3'd2, 32'h40, 32'h1234_5678, 1'b1);
      busIdle();
`ifdef AHB_WCHECK_EN
      checkVal("wchk_c1", {30'b0, lastReady, lastResp}, 32'b01);
      busIdle();
      checkVal("wchk_c2", {30'b0, lastReady, lastResp}, 32'b11);
      busRead(32'h40);
      busIdle();
      checkVal("wchk_old", lastRdata, 32'hAAAA_5555);
`else
      checkVal("wchk_ok", {30'b0, lastReady, lastResp}, 32'b10);
      busRead(32'h40);
      busIdle();
      checkVal("wchk_new", lastRdata, 32'h1234_5678);
`endif

      // Reset during a write data phase drops the write
      busWrite(32'h30, 32'h0F0F_0F0F, 3'd2);
      busIdle();
      busWrite(32'h30, 32'hFFFF_FFFF, 3'd2);
      resetDuring();
      busRead(32'h30);
      busIdle();
      checkVal("rst_dropwr", lastRdata, 32'h0F0F_0F0F);
      busRead(32'h10);
      resetDuring();

      // Preload a small window, then random traffic over it
      for (int i = 0; i < 32; i++) busWrite(32'(i * 4), $urandom, 3'd2);
      for (int n = 0; n < 3000; n++) begin
         s = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
         a = 32'($urandom_range(0, 127));
         if ($urandom_range(0, 1) == 1 && s <= 3'd2) a = a & ~((32'd1 << s) - 32'd1);
         if ($urandom_range(0, 15) == 0) a = REGION + 32'($urandom_range(0, 32'hFFFF));
         applyStimulus($urandom_range(0, 7) != 0, 2'($urandom), 1'($urandom), s, a,
                       $urandom, $urandom_range(0, 7) == 0);
      end
      busIdle();
      busIdle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ahb_ram_secded.md
Name: ahb_ram_secded

Overview:
- AHB-Lite single-port SRAM slave that sits directly downstream of the hardisc core's data or instruction bus.
- Terminates transfers, performs byte/halfword/word accesses, and returns read data together with the 7-bit SEC-DED checksum expected on s_x_hrchecksum_i.
- Rejects illegal transfers with a two-cycle AHB ERROR response.
- One instance per bus in the system top and in testbenches.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words; power of two, minimum 4.
- BASE_ADDR, 32'h0000_0000, base of the region; aligned to MEM_WORDS*4.

Ports:
- s_clk_i  input  1  clock.
- s_resetn_i  input  1  reset; asynchronous, active-low.
- s_hsel_i  input  1  slave select.
- s_haddr_i  input  32  address.
- s_htrans_i  input  2  transfer type; IDLE/BUSY are ignored.
- s_hwrite_i  input  1  write indicator.
- s_hsize_i  input  3  0 = byte, 1 = half, 2 = word.
- s_hready_i  input  1  bus-level hready; the address phase is accepted only when high.
- s_hwdata_i  input  32  write data (data phase).
- s_hwchecksum_i  input  7  SEC-DED checksum of s_hwdata_i.
- s_hrdata_o  output  32  read data.
- s_hrchecksum_o  output  7  SEC-DED checksum of s_hrdata_o.
- s_hreadyout_o  output  1  slave ready.
- s_hresp_o  output  1  error response.

Behaviour:
- Reset values: s_hreadyout_o=1, s_hresp_o=0, s_hrdata_o=0, s_hrchecksum_o=encode(0)=7'h00. All data-phase registers are cleared; the array is not reset.
- Reset asserted mid-transfer aborts the transfer: a pending write is dropped and no array update occurs.
- Address phase accept condition: s_hsel_i & s_hready_i & s_htrans_i[1].
  - On accept, register: write flag, word index s_haddr_i[log2(MEM_WORDS)+1:2], byte offset [1:0], size, and error class.
- Error classes, in priority order:
  - Out of range: s_haddr_i[31:log2(MEM_WORDS)+2] != BASE_ADDR of the same bits.
  - Size > 2.
  - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
- FSM states:
  - IDLE: no data phase pending.
  - DATA: legal transfer in its data phase.
  - ERR1: s_hreadyout_o=0, s_hresp_o=1.
  - ERR2: s_hreadyout_o=1, s_hresp_o=1.
- Transitions:
  - Accepted legal transfer -> DATA.
  - Accepted illegal transfer -> ERR1.
  - ERR1 -> ERR2 unconditionally.
  - DATA/ERR2 -> DATA/ERR1 if a new transfer is accepted in the same cycle, else IDLE.
- Reads are zero-wait.
  - In DATA with read flag: s_hrdata_o = array[index] (full word; the master selects lanes).
  - s_hrchecksum_o = encode(s_hrdata_o), combinational.
  - Outside read data phases both outputs are held at 0 / encode(0).
- Writes are zero-wait.
  - In DATA with write flag, write only the byte lanes selected by size/offset from s_hwdata_i, at the clock edge ending the data phase.
- Back-to-back write-then-read to the same word: the read data phase is the next cycle, so it observes the new value; no bypass is needed.
- Array is never written in ERR1/ERR2.

Optional Feature:
- Macro: AHB_WCHECK_EN.
- Defined:
  - In a write DATA phase, compare encode(s_hwdata_i) with s_hwchecksum_i.
  - On mismatch, suppress the write and extend the phase to a two-cycle ERROR: DATA acts as ERR1 (s_hreadyout_o=0, s_hresp_o=1), then ERR2.
  - A transfer accepted during that first cycle is ignored because s_hready_i is low.
- Undefined: s_hwchecksum_i is unused and all legal writes complete OKAY.

Decomposition:
- Shared package:
  - Function secded_enc32 (32->7 Hamming plus overall parity, bit order identical to the core's checker).
  - State enum ahb_ram_st_t {IDLE, DATA, ERR1, ERR2}.
  - Constants HTRANS_NONSEQ, HTRANS_SEQ and HSIZE_* codes.
- Sub-module secded_encoder_32: wraps secded_enc32; instantiated for read data and, with AHB_WCHECK_EN, for write data.

Test Plan:
- Word write of 0xDEADBEEF to 0x10, then word read of 0x10 -> s_hrdata_o=0xDEADBEEF, s_hrchecksum_o=secded_enc32(0xDEADBEEF), s_hreadyout_o=1 throughout, s_hresp_o=0.
- Byte write of 0x5A to 0x13 over a stored 0x11223344 -> subsequent word read returns 0x5A223344; halfword write of 0xBEEF to 0x12 -> read returns 0xBEEF3344.
- Word read at 0x2 (misaligned), and word read at BASE+MEM_WORDS*4 -> cycle 1 hreadyout=0 hresp=1, cycle 2 hreadyout=1 hresp=1, array unchanged.
- Back-to-back pipelined write(0x20, 0xCAFEF00D), read(0x20), read(0x24) -> reads return 0xCAFEF00D and the prior content of 0x24 with zero wait states.
- With AHB_WCHECK_EN: word write of 0x12345678 with checksum bit 0 flipped -> two-cycle ERROR, and a later read returns the old value. Without the macro the same stimulus writes 0x12345678 and responds OKAY.
- Reset asserted during the data phase of a write of 0xFFFFFFFF to 0x30 -> outputs take their reset values immediately, and a read of 0x30 after reset returns the pre-write value.
